// File: rtl/pc_pkg.sv
// Shared types for the fetch-address sequencer: decoded control classes.
package pc_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BR   = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_class_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/predictor-side bus of the fetch-address sequencer.
interface pc_sequencer_if
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned TS_WIDTH   = 64
);

    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_addr;
    op_class_e             op_class;
    logic [ADDR_WIDTH-1:0] target;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_taken_address;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ret_miss;
    logic [TS_WIDTH-1:0]   timestamp;

    modport master (
        output stall, flush, flush_addr, op_class, target, pred_taken, pred_target,
        input  pc, branch_taken, branch_taken_address, ras_empty, ras_full, ret_miss, timestamp
    );

    modport slave (
        input  stall, flush, flush_addr, op_class, target, pred_taken, pred_target,
        output pc, branch_taken, branch_taken_address, ras_empty, ras_full, ret_miss, timestamp
    );

endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_addr_stack #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top   = mem_q[ptr_q - PTR_W'(1)];

    // ptr_q is the next write slot; at full it also points at the oldest entry
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: next-pc selection, branch flags, RAS control and timestamp.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PC_INC     = 2,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned TS_WIDTH   = 64
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] bta_q, bta_d;
    logic [ADDR_WIDTH-1:0] pc_seq_c;
    logic [ADDR_WIDTH-1:0] ras_top_c;
    logic                  bt_q, bt_d;
    logic                  rm_q, rm_d;
    logic                  ras_push_c, ras_pop_c;
    logic                  ras_empty_c, ras_full_c;
    logic [TS_WIDTH-1:0]   ts_q;

    assign pc_seq_c = pc_q + ADDR_WIDTH'(PC_INC);

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push    (ras_push_c),
        .pop     (ras_pop_c),
        .data_in (pc_seq_c),
        .top     (ras_top_c),
        .empty   (ras_empty_c),
        .full    (ras_full_c)
    );

    // Next-pc selection: flush > stall > op_class; reserved classes fall through as SEQ
    always_comb begin
        pc_d       = pc_q;
        bt_d       = bt_q;
        bta_d      = bta_q;
        rm_d       = 1'b0;
        ras_push_c = 1'b0;
        ras_pop_c  = 1'b0;
        if (bus.flush) begin
            pc_d = bus.flush_addr;
            bt_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d = pc_seq_c;
            bt_d = 1'b0;
            case (bus.op_class)
                OP_JMP: pc_d = bus.target;
                OP_BR: begin
                    if (bus.pred_taken) begin
                        pc_d  = bus.pred_target;
                        bt_d  = 1'b1;
                        bta_d = bus.pred_target;
                    end
                end
                OP_CALL: begin
                    pc_d       = bus.target;
                    ras_push_c = 1'b1;
                end
                OP_RET: begin
                    if (!ras_empty_c) begin
                        pc_d      = ras_top_c;
                        ras_pop_c = 1'b1;
                    end else begin
                        rm_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= '0;
            bt_q  <= 1'b0;
            bta_q <= '0;
            rm_q  <= 1'b0;
            ts_q  <= '0;
        end else begin
            pc_q  <= pc_d;
            bt_q  <= bt_d;
            bta_q <= bta_d;
            rm_q  <= rm_d;
            ts_q  <= ts_q + TS_WIDTH'(1);
        end
    end

    assign bus.pc                   = pc_q;
    assign bus.branch_taken         = bt_q;
    assign bus.branch_taken_address = bta_q;
    assign bus.ras_empty            = ras_empty_c;
    assign bus.ras_full             = ras_full_c;
    assign bus.ret_miss             = rm_q;
    assign bus.timestamp            = ts_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_pc_sequencer;
    import pc_pkg::*;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [15:0] faddr;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic        pt;
        logic [15:0] ptgt;
        logic [15:0] e_pc;
        logic        e_bt;
        logic [15:0] e_bta;
        logic        e_empty;
        logic        e_full;
        logic        e_rm;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    // reference model state
    logic [15:0] m_pc, m_bta;
    logic        m_bt, m_rm;
    logic [63:0] m_ts;
    logic [15:0] m_ras[$];

    pc_sequencer_if #(.ADDR_WIDTH(16), .TS_WIDTH(64)) bus ();

    pc_sequencer #(
        .ADDR_WIDTH (16),
        .PC_INC     (2),
        .RAS_DEPTH  (4),
        .TS_WIDTH   (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, s, f, input logic [15:0] fa, input logic [2:0] op,
                              input logic [15:0] tg, input logic pt, input logic [15:0] ptg);
        if (r) begin
            m_pc = 0; m_bt = 0; m_bta = 0; m_rm = 0; m_ts = 0;
            m_ras.delete();
        end else begin
            m_ts = m_ts + 1;
            m_rm = 0;
            if (f) begin
                m_pc = fa;
                m_bt = 0;
            end else if (!s) begin
                m_bt = 0;
                if (op == 3'd1) m_pc = tg;
                else if (op == 3'd2 && pt) begin
                    m_pc = ptg; m_bt = 1; m_bta = ptg;
                end else if (op == 3'd3) begin
                    m_ras.push_back(m_pc + 16'd2);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                    m_pc = tg;
                end else if (op == 3'd4 && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    if (op == 3'd4) m_rm = 1;
                    m_pc = m_pc + 16'd2;
                end
            end
        end
    endtask

    task automatic drive(input logic r, s, f, input logic [15:0] fa, input logic [2:0] op,
                         input logic [15:0] tg, input logic pt, input logic [15:0] ptg);
        reset           = r;
        bus.stall       = s;
        bus.flush       = f;
        bus.flush_addr  = fa;
        bus.op_class    = op_class_e'(op);
        bus.target      = tg;
        bus.pred_taken  = pt;
        bus.pred_target = ptg;
        @(posedge clk);
        model_step(r, s, f, fa, op, tg, pt, ptg);
        #1;
    endtask

    task automatic add(input logic r, s, f, input logic [15:0] fa, input logic [2:0] op,
                       input logic [15:0] tg, input logic pt, input logic [15:0] ptg,
                       input logic [15:0] epc, input logic ebt, input logic [15:0] ebta,
                       input logic ee, ef, erm);
        vec_t v;
        v = '{r, s, f, fa, op, tg, pt, ptg, epc, ebt, ebta, ee, ef, erm};
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] e_ts;
        // rst stall flush faddr op tgt pt ptgt | pc bt bta empty full rm
        add(1,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);
        add(1,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);
        add(1,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0002,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0004,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0006,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0008,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   1,16'h10,  0,16'h0,    16'h0010,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   2,16'h0,   1,16'h40,   16'h0040,1,16'h0040,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0042,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   1,16'h20,  0,16'h0,    16'h0020,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   3,16'h100, 0,16'h0,    16'h0100,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0022,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   1,16'h0,   0,16'h0,    16'h0000,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   3,16'h100, 0,16'h0,    16'h0100,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   3,16'h200, 0,16'h0,    16'h0200,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   3,16'h300, 0,16'h0,    16'h0300,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   3,16'h400, 0,16'h0,    16'h0400,0,16'h0040,0,1,0);
        add(0,0,0,16'h0,   3,16'h500, 0,16'h0,    16'h0500,0,16'h0040,0,1,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0402,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0302,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0202,0,16'h0040,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0102,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0104,0,16'h0040,1,0,1);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0106,0,16'h0040,1,0,0);
        add(0,1,1,16'h80,  0,16'h0,   0,16'h0,    16'h0080,0,16'h0040,1,0,0);
        add(0,1,0,16'h0,   1,16'h999, 0,16'h0,    16'h0080,0,16'h0040,1,0,0);
        add(0,0,0,16'h0,   2,16'h0,   1,16'h200,  16'h0200,1,16'h0200,1,0,0);
        add(0,1,0,16'h0,   2,16'h0,   0,16'h0,    16'h0200,1,16'h0200,1,0,0);
        add(0,1,0,16'h0,   4,16'h0,   0,16'h0,    16'h0200,1,16'h0200,1,0,0);
        add(0,0,1,16'h300, 2,16'h0,   1,16'h500,  16'h0300,0,16'h0200,1,0,0);
        add(0,0,0,16'h0,   3,16'h600, 0,16'h0,    16'h0600,0,16'h0200,0,0,0);
        add(0,0,1,16'h700, 4,16'h0,   0,16'h0,    16'h0700,0,16'h0200,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0302,0,16'h0200,1,0,0);
        add(1,0,1,16'h80,  0,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   1,16'hFFFE,0,16'h0,    16'hFFFE,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   0,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   2,16'h0,   0,16'h1234, 16'h0002,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   7,16'h3000,1,16'h3000, 16'h0004,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   5,16'h3000,0,16'h0,    16'h0006,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   1,16'hFFFE,0,16'h0,    16'hFFFE,0,16'h0000,1,0,0);
        add(0,0,0,16'h0,   3,16'h10,  0,16'h0,    16'h0010,0,16'h0000,0,0,0);
        add(0,0,0,16'h0,   4,16'h0,   0,16'h0,    16'h0000,0,16'h0000,1,0,0);

        e_ts = 0;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.stall, v.flush, v.faddr, v.op, v.tgt, v.pt, v.ptgt);
            e_ts = v.rst ? 64'd0 : e_ts + 64'd1;
            chk($sformatf("vec[%0d].pc", i),    64'(bus.pc), 64'(v.e_pc));
            chk($sformatf("vec[%0d].bt", i),    64'(bus.branch_taken), 64'(v.e_bt));
            chk($sformatf("vec[%0d].bta", i),   64'(bus.branch_taken_address), 64'(v.e_bta));
            chk($sformatf("vec[%0d].empty", i), 64'(bus.ras_empty), 64'(v.e_empty));
            chk($sformatf("vec[%0d].full", i),  64'(bus.ras_full), 64'(v.e_full));
            chk($sformatf("vec[%0d].rm", i),    64'(bus.ret_miss), 64'(v.e_rm));
            chk($sformatf("vec[%0d].ts", i),    bus.timestamp, e_ts);
        end

        // randomized traffic against the reference model
        drive(1, 0, 0, 16'h0, 3'd0, 16'h0, 0, 16'h0);
        for (int c = 0; c < 3000; c++) begin
            logic r, s, f, pt;
            logic [2:0] op;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 7) == 0);
            pt = 1'($urandom);
            op = 3'($urandom_range(0, 4) == 0 ? $urandom_range(0, 7) : $urandom_range(0, 4));
            drive(r, s, f, 16'($urandom) & 16'hFFFE, op, 16'($urandom) & 16'hFFFE,
                  pt, 16'($urandom) & 16'hFFFE);
            chk($sformatf("rnd[%0d].pc", c),    64'(bus.pc), 64'(m_pc));
            chk($sformatf("rnd[%0d].bt", c),    64'(bus.branch_taken), 64'(m_bt));
            chk($sformatf("rnd[%0d].bta", c),   64'(bus.branch_taken_address), 64'(m_bta));
            chk($sformatf("rnd[%0d].empty", c), 64'(bus.ras_empty), 64'(m_ras.size() == 0));
            chk($sformatf("rnd[%0d].full", c),  64'(bus.ras_full), 64'(m_ras.size() == 4));
            chk($sformatf("rnd[%0d].rm", c),    64'(bus.ret_miss), 64'(m_rm));
            chk($sformatf("rnd[%0d].ts", c),    bus.timestamp, m_ts);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
